timing_impairment_sequencer: RTL and testbench

Synthesizable scheduler that drives a runtime-programmable fractional-delay interpolator in the MSK channel-impairment path.
- Steps through a programmable table of timing-impairment segments (initial offset, drift per sample, duration).
- Produces one fractional timing offset mu per input sample, with optional LFSR jitter.
- Supports single-pass or looped profiles, so long drift/jump scenarios run without testbench intervention.

---
 rtl/timing_imp_pkg.sv | 15 +
 rtl/timing_impairment_sequencer_lfsr.sv | 16 +
 rtl/timing_impairment_sequencer.sv | 131 +++++++++++++
 tb/tb_timing_impairment_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timing_imp_pkg.sv
// timing_imp_pkg: shared types and constants for the timing impairment sequencer
package timing_imp_pkg;
    localparam int SEG_OFF_W   = 16;
    localparam int SEG_DRIFT_W = 32;
    localparam int SEG_LEN_W   = 24;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic [SEG_OFF_W-1:0]   offset;
        logic [SEG_DRIFT_W-1:0] drift;
        logic [SEG_LEN_W-1:0]   len;
        logic                   reload;
    } seg_t;
endpackage

// File: rtl/timing_impairment_sequencer_lfsr.sv
// imp_lfsr16: 16-bit Galois right-shift LFSR; ports: clk, reset, en (advance), state (current value)
module imp_lfsr16
    import timing_imp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);
    logic [15:0] state_q, state_d;
    always_comb state_d = en ? ((state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 16'h0)) : state_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= LFSR_SEED;
        else       state_q <= state_d;
    assign state = state_q;
endmodule

// File: rtl/timing_impairment_sequencer.sv
// timing_impairment_sequencer: steps a segment table to emit one fractional offset mu per sample
// ports: cfg_* table write, num_seg_m1/loop_en/jitter_shift profile control, start/stop/sample_en,
//        mu_out/mu_valid result, seg_idx/seg_start/busy/done status
module timing_impairment_sequencer
    import timing_imp_pkg::*;
#(
    parameter int NUM_SEG = 8,
    parameter int MU_W    = 16,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_SEG)-1:0] cfg_addr,
    input  logic [MU_W-1:0]            cfg_offset,
    input  logic [ACC_W-1:0]           cfg_drift,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       cfg_reload,
    input  logic [$clog2(NUM_SEG)-1:0] num_seg_m1,
    input  logic                       loop_en,
    input  logic [3:0]                 jitter_shift,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       sample_en,
    output logic [MU_W-1:0]            mu_out,
    output logic                       mu_valid,
    output logic [$clog2(NUM_SEG)-1:0] seg_idx,
    output logic                       seg_start,
    output logic                       busy,
    output logic                       done
);
    localparam int IW = $clog2(NUM_SEG);
    seg_t tbl_q [NUM_SEG];
    seg_t tbl_d [NUM_SEG];
    seg_t cur;
    state_t state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, drift_q, drift_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [MU_W-1:0] mu_q, mu_d, jit;
    logic mu_valid_q, mu_valid_d, seg_start_q, seg_start_d;
    logic [IW-1:0] seg_idx_q, seg_idx_d, ld_idx;
    logic [15:0] lfsr;
    logic signed [MU_W-1:0] lfsr_ext, jit_sh;
    logic emit, seg_last, ld;

    imp_lfsr16 u_lfsr (.clk(clk), .reset(reset), .en(emit), .state(lfsr));

    // kept separate from the mux so the shift stays arithmetic
    assign lfsr_ext = MU_W'($signed(lfsr));
    assign jit_sh   = lfsr_ext >>> jitter_shift;
    assign jit      = (jitter_shift == 4'd0) ? '0 : jit_sh;

    assign emit     = !stop && state_q == RUN && sample_en;
    assign seg_last = emit && cnt_q == LEN_W'(1);

    // a segment load happens on start, or on the last sample of a segment so no sample is skipped
    always_comb begin
        ld = 1'b0;
        ld_idx = '0;
        if (!stop && state_q != RUN) ld = start;
        else if (seg_last) begin
            ld = (seg_idx_q != num_seg_m1) || loop_en;
            ld_idx = (seg_idx_q != num_seg_m1) ? seg_idx_q + IW'(1) : '0;
        end
    end
    assign cur = tbl_q[ld_idx];

    always_comb begin
        state_d = state_q;
        if (stop) state_d = IDLE;
        else if (state_q != RUN) state_d = start ? RUN : state_q;
        else if (seg_last && seg_idx_q == num_seg_m1 && !loop_en) state_d = DONE;
    end

    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we && int'(cfg_addr) < NUM_SEG) tbl_d[cfg_addr] = '{cfg_offset, cfg_drift, cfg_len, cfg_reload};
        acc_d = acc_q;
        cnt_d = cnt_q;
        drift_d = drift_q;
        mu_d = mu_q;
        mu_valid_d = 1'b0;
        seg_idx_d = seg_idx_q;
        seg_start_d = ld;
        if (emit) begin
            mu_d = acc_q[ACC_W-1 -: MU_W] + jit;
            mu_valid_d = 1'b1;
            acc_d = acc_q + drift_q;
            cnt_d = cnt_q - LEN_W'(1);
        end
        if (ld) begin
            seg_idx_d = ld_idx;
            cnt_d = (cur.len == '0) ? LEN_W'(1) : cur.len;
            drift_d = cur.drift;
            if (cur.reload) acc_d = {cur.offset, (ACC_W-MU_W)'(0)};
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_SEG; i++) tbl_q[i] <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            drift_q <= '0;
            mu_q <= '0;
            mu_valid_q <= 1'b0;
            seg_idx_q <= '0;
            seg_start_q <= 1'b0;
        end else begin
            tbl_q <= tbl_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            drift_q <= drift_d;
            mu_q <= mu_d;
            mu_valid_q <= mu_valid_d;
            seg_idx_q <= seg_idx_d;
            seg_start_q <= seg_start_d;
        end

    assign mu_out    = mu_q;
    assign mu_valid  = mu_valid_q;
    assign seg_idx   = seg_idx_q;
    assign seg_start = seg_start_q;
    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_timing_impairment_sequencer.sv
// tb_timing_impairment_sequencer: directed self-checking bench for timing_impairment_sequencer
module tb_timing_impairment_sequencer;
    logic clk = 0, reset = 0, cfg_we = 0, cfg_reload = 0, loop_en = 0;
    logic start = 0, stop = 0, sample_en = 0;
    logic [2:0] cfg_addr = 0, num_seg_m1 = 0;
    logic [15:0] cfg_offset = 0;
    logic [31:0] cfg_drift = 0;
    logic [23:0] cfg_len = 0;
    logic [3:0] jitter_shift = 0;
    logic [15:0] mu_out;
    logic mu_valid, seg_start, busy, done;
    logic [2:0] seg_idx;
    int checks = 0, failures = 0;

    timing_impairment_sequencer dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_offset(cfg_offset), .cfg_drift(cfg_drift), .cfg_len(cfg_len),
        .cfg_reload(cfg_reload), .num_seg_m1(num_seg_m1), .loop_en(loop_en),
        .jitter_shift(jitter_shift), .start(start), .stop(stop), .sample_en(sample_en),
        .mu_out(mu_out), .mu_valid(mu_valid), .seg_idx(seg_idx), .seg_start(seg_start),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_seg(input int a, input logic [15:0] off, input logic [31:0] dr, input logic [23:0] len, input logic rl);
        cfg_we = 1; cfg_addr = 3'(a); cfg_offset = off; cfg_drift = dr; cfg_len = len; cfg_reload = rl;
        tick;
        cfg_we = 0;
    endtask

    task automatic do_reset;
        reset = 1;
        tick;
        tick;
        reset = 0;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if ({mu_out, mu_valid, seg_idx, seg_start, busy, done} !== 23'd0) begin
            failures++; $display("FAIL reset outputs got %h expected 0", {mu_out, mu_valid, seg_idx, seg_start, busy, done});
        end
    endtask

    task automatic test_const;
        wr_seg(0, 16'h4000, 32'h0, 24'd4, 1'b1);
        num_seg_m1 = 0; loop_en = 0; jitter_shift = 0;
        start = 1; tick; start = 0;
        checks++; if (busy !== 1'b1 || seg_start !== 1'b1 || mu_valid !== 1'b0) begin
            failures++; $display("FAIL const_start busy=%b seg_start=%b mu_valid=%b expected 1 1 0", busy, seg_start, mu_valid);
        end
        sample_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (mu_valid !== 1'b1 || mu_out !== 16'h4000) begin
                failures++; $display("FAIL const_mu[%0d] valid=%b mu=%h expected 1 4000", i, mu_valid, mu_out);
            end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL const_done done=%b busy=%b expected 1 0", done, busy);
        end
        tick;
        sample_en = 0;
        checks++; if (mu_valid !== 1'b0 || mu_out !== 16'h4000) begin
            failures++; $display("FAIL const_hold valid=%b mu=%h expected 0 4000", mu_valid, mu_out);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] e [4];
        e = '{16'h7FF0, 16'h7FF8, 16'h8000, 16'h8008};
        wr_seg(0, 16'h7FF0, 32'h0008_0000, 24'd4, 1'b1);
        start = 1; tick; start = 0;
        sample_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (mu_valid !== 1'b1 || mu_out !== e[i]) begin
                failures++; $display("FAIL wrap_mu[%0d] valid=%b mu=%h expected 1 %h", i, mu_valid, mu_out, e[i]);
            end
        end
        sample_en = 0;
    endtask

    task automatic test_two_seg;
        logic [15:0] e [4];
        e = '{16'h0000, 16'h0001, 16'h0002, 16'h0004};
        wr_seg(0, 16'h0000, 32'h0001_0000, 24'd2, 1'b1);
        wr_seg(1, 16'h4000, 32'h0002_0000, 24'd2, 1'b0);
        num_seg_m1 = 1; loop_en = 0;
        start = 1; tick; start = 0;
        checks++; if (seg_start !== 1'b1 || seg_idx !== 3'd0) begin
            failures++; $display("FAIL two_seg_start seg_start=%b idx=%0d expected 1 0", seg_start, seg_idx);
        end
        sample_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (mu_valid !== 1'b1 || mu_out !== e[i] || seg_start !== (i == 1)) begin
                failures++; $display("FAIL two_seg[%0d] valid=%b mu=%h seg_start=%b expected 1 %h %b", i, mu_valid, mu_out, seg_start, e[i], i == 1);
            end
        end
        sample_en = 0;
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL two_seg_done done=%b expected 1", done);
        end
    endtask

    task automatic test_loop;
        logic [15:0] e [4];
        logic [2:0] s [4];
        e = '{16'h0000, 16'h0001, 16'h0002, 16'h0004};
        s = '{3'd0, 3'd0, 3'd1, 3'd1};
        loop_en = 1;
        start = 1; tick; start = 0;
        sample_en = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (seg_idx !== s[i%4]) begin
                failures++; $display("FAIL loop_idx[%0d] got %0d expected %0d", i, seg_idx, s[i%4]);
            end
            tick;
            checks++; if (mu_valid !== 1'b1 || mu_out !== e[i%4]) begin
                failures++; $display("FAIL loop_mu[%0d] valid=%b mu=%h expected 1 %h", i, mu_valid, mu_out, e[i%4]);
            end
        end
        stop = 1; tick; stop = 0; sample_en = 0;
        loop_en = 0; num_seg_m1 = 0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL loop_stop busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_stop;
        wr_seg(0, 16'h1000, 32'h0001_0000, 24'd8, 1'b1);
        start = 1; tick; start = 0;
        sample_en = 1;
        tick;
        tick;
        checks++; if (mu_out !== 16'h1001) begin
            failures++; $display("FAIL stop_pre mu=%h expected 1001", mu_out);
        end
        stop = 1; start = 1; tick; stop = 0; start = 0; sample_en = 0;
        checks++; if (mu_valid !== 1'b0 || busy !== 1'b0 || mu_out !== 16'h1001) begin
            failures++; $display("FAIL stop_cycle valid=%b busy=%b mu=%h expected 0 0 1001", mu_valid, busy, mu_out);
        end
        start = 1; tick; start = 0;
        checks++; if (busy !== 1'b1 || seg_start !== 1'b1) begin
            failures++; $display("FAIL stop_restart busy=%b seg_start=%b expected 1 1", busy, seg_start);
        end
        sample_en = 1; tick; sample_en = 0;
        checks++; if (mu_valid !== 1'b1 || mu_out !== 16'h1000) begin
            failures++; $display("FAIL stop_reload valid=%b mu=%h expected 1 1000", mu_valid, mu_out);
        end
        stop = 1; tick; stop = 0;
    endtask

    task automatic test_len_zero;
        wr_seg(0, 16'h0100, 32'h0, 24'd0, 1'b1);
        start = 1; tick; start = 0;
        sample_en = 1; tick; sample_en = 0;
        checks++; if (mu_valid !== 1'b1 || mu_out !== 16'h0100 || done !== 1'b1) begin
            failures++; $display("FAIL len_zero valid=%b mu=%h done=%b expected 1 0100 1", mu_valid, mu_out, done);
        end
    endtask

    task automatic test_jitter;
        logic [15:0] e [4];
        e = '{16'h3ACE, 16'h3E27, 16'h4713, 16'h4389};
        do_reset;
        wr_seg(0, 16'h4000, 32'h0, 24'd4, 1'b1);
        num_seg_m1 = 0; loop_en = 0; jitter_shift = 4;
        start = 1; tick; start = 0;
        sample_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (mu_valid !== 1'b1 || mu_out !== e[i]) begin
                failures++; $display("FAIL jitter_mu[%0d] valid=%b mu=%h expected 1 %h", i, mu_valid, mu_out, e[i]);
            end
        end
        sample_en = 0;
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL jitter_done done=%b expected 1", done);
        end
    endtask

    initial begin
        test_reset;
        test_const;
        test_wrap;
        test_two_seg;
        test_loop;
        test_stop;
        test_len_zero;
        test_jitter;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
